// File: rtl/rvb_pkg.sv
// Shared definitions for the carry-less multiply issue block:
// FSM state encoding, operation select values and the default tag width.
package rvb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Value of the captured "high" bit that selects each multiplier operation.
    localparam logic OP_CLMUL  = 1'b0;
    localparam logic OP_CLMULH = 1'b1;

    localparam int TAG_W_DEF = 5;

endpackage

// File: rtl/rvb_clmul_issue_if.sv
// Bundle of the three handshakes around the CLMUL issue block:
// core request, multiplier operand/result port and writeback response.
// The master modport is the issue block itself; slave is its environment.
interface rvb_clmul_issue_if
    import rvb_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) ();

    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic             req_high;
    logic [TAG_W-1:0] req_tag;
    logic             flush;

    logic             unit_din_ready;
    logic             unit_din_valid;
    logic [31:0]      unit_rs1;
    logic [31:0]      unit_rs2;
    logic             unit_op_clmul;
    logic             unit_op_clmulh;
    logic             unit_dout_valid;
    logic [31:0]      unit_dout_rd;

    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_err;
    logic             busy;

    modport master (
        input  req_valid, req_rs1, req_rs2, req_high, req_tag, flush,
        input  unit_din_ready, unit_dout_valid, unit_dout_rd,
        input  wb_ready,
        output req_ready,
        output unit_din_valid, unit_rs1, unit_rs2, unit_op_clmul, unit_op_clmulh,
        output wb_valid, wb_data, wb_tag, wb_err, busy
    );

    modport slave (
        output req_valid, req_rs1, req_rs2, req_high, req_tag, flush,
        output unit_din_ready, unit_dout_valid, unit_dout_rd,
        output wb_ready,
        input  req_ready,
        input  unit_din_valid, unit_rs1, unit_rs2, unit_op_clmul, unit_op_clmulh,
        input  wb_valid, wb_data, wb_tag, wb_err, busy
    );

endinterface

// File: rtl/rvb_clmul_issue.sv
// Issue/collect FSM for the multi-cycle carry-less multiplier. Holds one
// request, launches it into the unit, waits (with watchdog) for the result
// and buffers it until writeback takes it. A flush that arrives after the
// operands were launched marks the request as dropped so the late result is
// swallowed instead of leaking into the next request.
module rvb_clmul_issue
    import rvb_pkg::*;
#(
    parameter int TAG_W   = TAG_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    rvb_clmul_issue_if.master bus
);

    // Counter holds 0..TIMEOUT; expiry is detected in the last allowed cycle.
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_drop;
    logic             w_drop_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic [31:0]      r_rs1;
    logic [31:0]      r_rs2;
    logic             r_high;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_wb_data;

    logic             w_accept;
    logic             w_dout;
    logic             w_expire;
    logic             w_kill;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid && !bus.flush;
    assign w_dout   = (r_state == ST_WAIT) && bus.unit_dout_valid;
    // A result arriving in the final cycle still wins over the timeout.
    assign w_expire = (r_state == ST_WAIT) && !bus.unit_dout_valid && (r_cnt == CNT_LAST);
    assign w_kill   = r_drop || bus.flush;

    // State, drop flag, watchdog counter and error flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic, including drop/counter/error bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                w_drop_nxt = 1'b0;
                w_cnt_nxt  = '0;
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.unit_din_ready) begin
                    // Operands are launched even if flushed now; remember to drop.
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = '0;
                    w_drop_nxt  = bus.flush;
                end else if (bus.flush) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_dout) begin
                    if (w_kill) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_err_nxt   = 1'b0;
                    end
                end else if (w_expire) begin
                    if (w_kill) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_err_nxt   = 1'b1;
                    end
                end else if (bus.flush) begin
                    w_drop_nxt = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.wb_ready || bus.flush) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture and result buffer; data path needs no reset.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_rs1  <= bus.req_rs1;
            r_rs2  <= bus.req_rs2;
            r_high <= bus.req_high;
            r_tag  <= bus.req_tag;
        end
        if (w_dout && !w_kill) begin
            r_wb_data <= bus.unit_dout_rd;
        end else if (w_expire && !w_kill) begin
            r_wb_data <= '0;
        end
    end

    // Outputs decoded from the current state and the held registers.
    always_comb begin
        bus.req_ready      = (r_state == ST_IDLE);
        bus.unit_din_valid = (r_state == ST_ISSUE);
        bus.unit_op_clmul  = (r_state == ST_ISSUE) && (r_high == OP_CLMUL);
        bus.unit_op_clmulh = (r_state == ST_ISSUE) && (r_high == OP_CLMULH);
        bus.unit_rs1       = r_rs1;
        bus.unit_rs2       = r_rs2;
        bus.wb_valid       = (r_state == ST_RESP);
        bus.wb_err         = (r_state == ST_RESP) && r_err;
        bus.wb_data        = r_wb_data;
        bus.wb_tag         = r_tag;
        bus.busy           = (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_rvb_clmul_issue.sv
// Bench for rvb_clmul_issue: a behavioural multi-cycle CLMUL unit with
// programmable latency, a table of directed vectors, hand sequences for
// flush/timeout/reset/backpressure corners and a randomized phase.
module tb_rvb_clmul_issue;

    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 15;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rvb_clmul_issue_if #(.TAG_W(TAG_W)) bus ();

    rvb_clmul_issue #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Carry-less product from its definition: XOR of shifted copies of a.
    function automatic logic [63:0] clmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) acc = acc ^ ({32'b0, a} << i);
        end
        return acc;
    endfunction

    // Multiplier model: result pulse visible lat cycles after the operand handshake.
    int          unit_lat  = 4;
    logic        unit_dead = 1'b0;
    int          rdy_mode  = 1;   // 0: never ready, 1: ready when free, 2: random
    logic        rdy_rand  = 1'b0;
    logic        inj       = 1'b0;
    logic        m_pend;
    logic        m_vld;
    int          m_cnt;
    logic [31:0] m_rd;

    always @(negedge clock) rdy_rand <= 1'($urandom_range(0, 1));

    assign bus.unit_din_ready  = !m_pend && ((rdy_mode == 1) || (rdy_mode == 2 && rdy_rand));
    assign bus.unit_dout_valid = m_vld | inj;
    assign bus.unit_dout_rd    = inj ? 32'hDEADBEEF : m_rd;

    always @(posedge clock) begin
        if (reset) begin
            m_pend <= 1'b0;
            m_vld  <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_vld <= 1'b0;
            if (m_pend) begin
                if (m_cnt <= 1) begin
                    m_pend <= 1'b0;
                    m_vld  <= !unit_dead;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (bus.unit_din_valid && bus.unit_din_ready) begin
                m_pend <= 1'b1;
                m_cnt  <= unit_lat;
                if (bus.unit_op_clmulh && !bus.unit_op_clmul)
                    m_rd <= clmul_ref(bus.unit_rs1, bus.unit_rs2) >> 32;
                else if (bus.unit_op_clmul && !bus.unit_op_clmulh)
                    m_rd <= clmul_ref(bus.unit_rs1, bus.unit_rs2) & 64'hFFFF_FFFF;
                else
                    m_rd <= 32'hBAD0BAD0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present a request until accepted; operands are scrambled afterwards.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic h,
                         input logic [TAG_W-1:0] t);
        logic ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.req_high  = h;
        bus.req_tag   = t;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.req_ready && !bus.flush) ok = 1'b1;
            tick();
        end
        bus.req_valid = 1'b0;
        bus.req_rs1   = $urandom;
        bus.req_rs2   = $urandom;
        bus.req_high  = ~h;
        bus.req_tag   = ~t;
        chk("req_accepted", ok, 1);
    endtask

    // Wait for the writeback handshake and compare the delivered response.
    task automatic collect(input logic [31:0] ed, input logic [TAG_W-1:0] et,
                           input logic ee, input logic rnd);
        logic done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            bus.wb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.wb_valid && bus.wb_ready) begin
                chk("wb_data", bus.wb_data, ed);
                chk("wb_tag", bus.wb_tag, et);
                chk("wb_err", bus.wb_err, ee);
                done = 1'b1;
            end
            tick();
        end
        bus.wb_ready = 1'b0;
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL wb_handshake: no response within 300 cycles");
        end
    endtask

    task automatic drain();
        bus.wb_ready = 1'b1;
        repeat (30) tick();
        bus.wb_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic             high;
        logic [TAG_W-1:0] tag;
        int               lat;
        logic [31:0]      exp_data;
        logic             exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic        saw_wb;
        logic        saw_dout;
        int          k;
        logic [31:0] a, b;
        logic        h, e;
        logic [4:0]  t;
        logic [31:0] d;
        logic [63:0] full;
        int          lat;

        vecs[0] = '{32'h0000_0003, 32'h0000_0003, 1'b0, 5'd7,  4,  32'h0000_0005, 1'b0};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 5'd1,  4,  32'h4000_0000, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd2,  3,  32'h5555_5555, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd3,  2,  32'h5555_5555, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h0000_0001, 1'b0, 5'd31, 1,  32'h1234_5678, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0002, 1'b1, 5'd4,  5,  32'h0000_0001, 1'b0};
        vecs[6] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 5'd5,  14, 32'h0000_000F, 1'b0};
        vecs[7] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 5'd6,  15, 32'h0000_0000, 1'b1};
        vecs[8] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 5'd8,  20, 32'h0000_0000, 1'b1};

        bus.req_valid = 1'b0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_high  = 1'b0;
        bus.req_tag   = '0;
        bus.flush     = 1'b0;
        bus.wb_ready  = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_din_valid", bus.unit_din_valid, 0);
        chk("rst_op", {bus.unit_op_clmul, bus.unit_op_clmulh}, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_err", bus.wb_err, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        tick();

        // Directed vectors, including both sides of the watchdog deadline
        rdy_mode = 1;
        for (int i = 0; i < 9; i++) begin
            unit_lat = vecs[i].lat;
            issue(vecs[i].rs1, vecs[i].rs2, vecs[i].high, vecs[i].tag);
            collect(vecs[i].exp_data, vecs[i].tag, vecs[i].exp_err, 1'b0);
            chk("busy_after_wb", bus.busy, 0);
            chk("req_ready_after_wb", bus.req_ready, 1);
        end
        drain();

        // Writeback backpressure, then back-to-back acceptance
        unit_lat = 4;
        issue(32'h3, 32'h5, 1'b0, 5'd9);
        for (int i = 0; i < 60 && !bus.wb_valid; i++) tick();
        chk("bp_wb_valid", bus.wb_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_wb_data_held", bus.wb_data, 32'hF);
            chk("bp_wb_tag_held", bus.wb_tag, 9);
            chk("bp_req_ready_low", bus.req_ready, 0);
            tick();
        end
        bus.wb_ready = 1'b1;
        tick();
        chk("bp_released_wb_valid", bus.wb_valid, 0);
        chk("bp_released_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_rs1   = 32'h8000_0000;
        bus.req_rs2   = 32'h0000_0002;
        bus.req_high  = 1'b1;
        bus.req_tag   = 5'd10;
        tick();
        bus.req_valid = 1'b0;
        chk("bp_next_accepted", bus.busy, 1);
        chk("bp_next_clmulh", bus.unit_op_clmulh, 1);
        collect(32'h1, 5'd10, 1'b0, 1'b0);
        drain();

        // Flush two cycles after the unit handshake: result swallowed
        unit_lat = 6;
        issue(32'h7, 32'h9, 1'b0, 5'd11);
        tick();
        chk("fw_in_wait_busy", bus.busy, 1);
        chk("fw_in_wait_din", bus.unit_din_valid, 0);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        saw_wb = 1'b0;
        saw_dout = 1'b0;
        for (int i = 0; i < 15; i++) begin
            saw_wb   = saw_wb | bus.wb_valid;
            saw_dout = saw_dout | bus.unit_dout_valid;
            tick();
        end
        chk("fw_no_wb", saw_wb, 0);
        chk("fw_dout_seen", saw_dout, 1);
        chk("fw_idle", bus.busy, 0);
        drain();

        // Flush together with the operand handshake
        unit_lat = 4;
        issue(32'h7, 32'h9, 1'b1, 5'd12);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fi_launched_wait", bus.busy, 1);
        saw_wb = 1'b0;
        for (int i = 0; i < 15; i++) begin
            saw_wb = saw_wb | bus.wb_valid;
            tick();
        end
        chk("fi_no_wb", saw_wb, 0);
        chk("fi_idle", bus.busy, 0);
        drain();

        // Flush in ISSUE before the unit takes the operands
        rdy_mode = 0;
        issue(32'h7, 32'h9, 1'b0, 5'd13);
        chk("fs_issue_din", bus.unit_din_valid, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fs_idle", bus.busy, 0);
        chk("fs_din_low", bus.unit_din_valid, 0);
        chk("fs_unit_untouched", m_pend, 0);

        // Flush in IDLE blocks acceptance
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        chk("fidle_not_taken", bus.busy, 0);

        // Flush in RESP drops the buffered result
        rdy_mode = 1;
        unit_lat = 2;
        issue(32'h7, 32'h9, 1'b0, 5'd14);
        for (int i = 0; i < 60 && !bus.wb_valid; i++) tick();
        chk("fr_wb_valid", bus.wb_valid, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fr_wb_gone", bus.wb_valid, 0);
        chk("fr_idle", bus.busy, 0);
        drain();

        // Watchdog: silent unit, error response exactly TIMEOUT cycles into WAIT
        unit_dead = 1'b1;
        unit_lat  = 3;
        issue(32'h3, 32'h3, 1'b0, 5'd15);
        tick();
        k = 0;
        for (int i = 0; i < 40 && !bus.wb_valid; i++) begin
            tick();
            k++;
        end
        chk("to_cycles", k, TIMEOUT);
        chk("to_wb_err", bus.wb_err, 1);
        chk("to_wb_data", bus.wb_data, 0);
        chk("to_wb_tag", bus.wb_tag, 15);
        unit_dead = 1'b0;
        drain();

        // Stray result pulse in IDLE is ignored
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        chk("stray_busy", bus.busy, 0);
        chk("stray_wb", bus.wb_valid, 0);

        // Reset while stuck in ISSUE
        rdy_mode = 0;
        issue(32'h3, 32'h3, 1'b1, 5'd16);
        chk("rsti_din_valid", bus.unit_din_valid, 1);
        chk("rsti_clmulh", bus.unit_op_clmulh, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rsti_din_low", bus.unit_din_valid, 0);
        chk("rsti_req_ready", bus.req_ready, 1);
        chk("rsti_busy", bus.busy, 0);
        tick();

        // Randomized operands, latencies, unit readiness and writeback stalls
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            a    = $urandom;
            b    = $urandom;
            h    = 1'($urandom_range(0, 1));
            t    = 5'($urandom_range(0, 31));
            lat  = $urandom_range(1, 17);
            full = clmul_ref(a, b);
            e    = (lat >= TIMEOUT);
            d    = e ? 32'h0 : (h ? full[63:32] : full[31:0]);
            unit_lat = lat;
            issue(a, b, h, t);
            chk("rnd_busy_after_accept", bus.busy, 1);
            collect(d, t, e, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
